// File: rtl/pc_redirect_unit_pkg.sv
// Shared types and constants for the fetch-side PC redirect unit.
// Optional feature macro: PC_REDIRECT_MISALIGN_TRAP_EN.
package pc_redirect_unit_pkg;

    localparam int unsigned PC_W        = 32;
    localparam int unsigned FLUSH_CNT_W = 3;

    localparam logic [PC_W-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [PC_W-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HOLD      = 2'd1,
        HOLD_PEND = 2'd2,
        FLUSH     = 2'd3
    } state_t;

`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
    localparam logic [PC_W-1:0] NORM_MASK = 32'hFFFF_FFFE;
`else
    localparam logic [PC_W-1:0] NORM_MASK = 32'hFFFF_FFFC;
`endif

    // Bit1 survives only when the misalign trap is built in, so it can be detected.
    function automatic logic [PC_W-1:0] normalise_target(input logic [PC_W-1:0] target);
        return target & NORM_MASK;
    endfunction

endpackage

// File: rtl/pc_flush_counter.sv
// Flush-window counter: loads on redirect, counts down on non-stalled cycles,
// and owns the registered flush flag.
module pc_flush_counter
    import pc_redirect_unit_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic stall,
    output logic flush,
    output logic done
);

    logic [FLUSH_CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            flush <= 1'b0;
        end else if (load) begin
            count <= FLUSH_CNT_W'(FLUSH_CYCLES);
            flush <= 1'b1;
        end else if (flush && !stall) begin
            count <= count - 3'd1;
            if (count == 3'd1)
                flush <= 1'b0;
        end
    end

    assign done = flush && !stall && (count == 3'd1);

endmodule

// File: rtl/pc_redirect_unit.sv
// Architectural PC, sequential PC+4 path, stall-latched redirects and flush pulses.
// Optional feature macro: PC_REDIRECT_MISALIGN_TRAP_EN (misaligned redirect traps).
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int unsigned     FLUSH_CYCLES = 2,
    parameter logic [PC_W-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            branch_jump_mux_signal,
    input  logic [PC_W-1:0] Branch_jump_PC_OUT,
    input  logic            busywait,
    output logic [PC_W-1:0] PC,
    output logic [PC_W-1:0] PC_plus_4,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            redirect_pending,
    output logic            misalign_trap
);

    state_t          state, next_state;
    logic [PC_W-1:0] next_pc, pend_target, next_pend;
    logic [PC_W-1:0] req_target, apply_target;
    logic            apply, load_flush, flush, flush_done;
    logic            trap_next;

    assign req_target = normalise_target(Branch_jump_PC_OUT);

    pc_flush_counter #(
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) u_flush_counter (
        .clk  (CLK),
        .rst_n(RESET),
        .load (load_flush),
        .stall(busywait),
        .flush(flush),
        .done (flush_done)
    );

    always_comb begin
        next_state   = state;
        next_pc      = PC;
        next_pend    = pend_target;
        apply        = 1'b0;
        apply_target = req_target;
        load_flush   = 1'b0;
        trap_next    = 1'b0;

        case (state)
            RUN, HOLD: begin
                if (busywait) begin
                    if (branch_jump_mux_signal) begin
                        next_pend  = req_target;
                        next_state = HOLD_PEND;
                    end else begin
                        next_state = HOLD;
                    end
                end else if (branch_jump_mux_signal) begin
                    apply = 1'b1;
                end else begin
                    next_pc    = PC + 32'd4;
                    next_state = RUN;
                end
            end
            // EX is frozen and re-presents the same branch, so later requests are ignored.
            HOLD_PEND: begin
                if (!busywait) begin
                    apply        = 1'b1;
                    apply_target = pend_target;
                end
            end
            FLUSH: begin
                if (!busywait) begin
                    next_pc = PC + 32'd4;
                    if (flush_done)
                        next_state = RUN;
                end
            end
        endcase

        if (apply) begin
            load_flush = 1'b1;
            next_state = FLUSH;
`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
            if (apply_target[1]) begin
                next_pc   = TRAP_VECTOR;
                trap_next = 1'b1;
            end else begin
                next_pc = apply_target;
            end
`else
            next_pc = apply_target;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= RUN;
            PC          <= RESET_VECTOR;
            pend_target <= '0;
        end else begin
            state       <= next_state;
            PC          <= next_pc;
            pend_target <= next_pend;
        end
    end

`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            misalign_trap <= 1'b0;
        else
            misalign_trap <= trap_next;
    end
`else
    logic unused_trap;
    assign unused_trap   = ^{TRAP_VECTOR, trap_next};
    assign misalign_trap = 1'b0;
`endif

    assign PC_plus_4        = PC + 32'd4;
    assign if_id_flush      = flush;
    assign id_ex_flush      = flush;
    assign redirect_pending = (state == HOLD_PEND);

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Table-driven and randomized checks of pc_redirect_unit against a behavioural model.
module tb_pc_redirect_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;
    localparam int unsigned FC = 2;
`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif
    localparam logic [31:0] EXP_MIS = MIS_EN ? 32'h100 : 32'h104;

    logic        CLK = 1'b0, RESET = 1'b0, redir = 1'b0, bw = 1'b0;
    logic [31:0] tgt = '0;
    logic [31:0] PC, PC_plus_4;
    logic        if_id_flush, id_ex_flush, redirect_pending, misalign_trap;

    pc_redirect_unit #(
        .RESET_VECTOR(RV),
        .FLUSH_CYCLES(FC),
        .TRAP_VECTOR (TV)
    ) dut (
        .CLK                   (CLK),
        .RESET                 (RESET),
        .branch_jump_mux_signal(redir),
        .Branch_jump_PC_OUT    (tgt),
        .busywait              (bw),
        .PC                    (PC),
        .PC_plus_4             (PC_plus_4),
        .if_id_flush           (if_id_flush),
        .id_ex_flush           (id_ex_flush),
        .redirect_pending      (redirect_pending),
        .misalign_trap         (misalign_trap)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        r;
        logic [31:0] t;
        logic        b;
        logic [31:0] pc;
        logic        f;
        logic        p;
        logic        tr;
    } vec_t;
    vec_t vt[$];

    // Behavioural model: flush window counted as cycles remaining until it closes.
    logic [31:0] m_pc, m_pt;
    int          m_left;
    bit          m_pend, m_trap;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input bit f,
                             input bit p, input bit tr);
        chk($sformatf("%s pc", tag), PC, pc);
        chk($sformatf("%s pc4", tag), PC_plus_4, pc + 32'd4);
        chk($sformatf("%s if_id_flush", tag), 32'(if_id_flush), 32'(f));
        chk($sformatf("%s id_ex_flush", tag), 32'(id_ex_flush), 32'(f));
        chk($sformatf("%s pending", tag), 32'(redirect_pending), 32'(p));
        chk($sformatf("%s trap", tag), 32'(misalign_trap), 32'(tr));
    endtask

    function automatic void add(input bit r, input logic [31:0] t, input bit b,
                                input logic [31:0] pc, input bit f, input bit p, input bit tr);
        vec_t v;
        v.r = r; v.t = t; v.b = b; v.pc = pc; v.f = f; v.p = p; v.tr = tr;
        vt.push_back(v);
    endfunction

    // Called positioned just after a falling edge; returns positioned the same way.
    task automatic run_vec(input string tag, input vec_t v);
        redir = v.r; tgt = v.t; bw = v.b;
        @(posedge CLK); #1;
        check_all(tag, v.pc, v.f, v.p, v.tr);
        @(negedge CLK);
    endtask

    task automatic model_apply(input logic [31:0] t_in);
        logic [31:0] t;
        t = t_in;
        t[0] = 1'b0;
        if (!MIS_EN) t[1] = 1'b0;
        if (MIS_EN && t[1]) begin
            m_pc   = TV;
            m_trap = 1'b1;
        end else begin
            m_pc = t;
        end
        m_left = FC;
    endtask

    task automatic model_step(input bit r, input logic [31:0] t, input bit b);
        m_trap = 1'b0;
        if (m_left > 0) begin
            if (!b) begin
                m_pc = m_pc + 32'd4;
                m_left--;
            end
        end else if (m_pend) begin
            if (!b) begin
                m_pend = 1'b0;
                model_apply(m_pt);
            end
        end else if (b) begin
            if (r) begin
                m_pend = 1'b1;
                m_pt   = t;
            end
        end else if (r) begin
            model_apply(t);
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    initial begin
        // Sequential fetch
        add(0, 0, 0, 32'h04, 0, 0, 0);
        add(0, 0, 0, 32'h08, 0, 0, 0);
        add(0, 0, 0, 32'h0C, 0, 0, 0);
        add(0, 0, 0, 32'h10, 0, 0, 0);
        add(0, 0, 0, 32'h14, 0, 0, 0);
        add(0, 0, 0, 32'h18, 0, 0, 0);
        add(0, 0, 0, 32'h1C, 0, 0, 0);
        add(0, 0, 0, 32'h20, 0, 0, 0);
        // Unstalled redirect, two-cycle flush
        add(1, 32'h80, 0, 32'h80, 1, 0, 0);
        add(0, 0, 0, 32'h84, 1, 0, 0);
        add(0, 0, 0, 32'h88, 0, 0, 0);
        add(1, 32'h38, 0, 32'h38, 1, 0, 0);
        add(0, 0, 0, 32'h3C, 1, 0, 0);
        add(0, 0, 0, 32'h40, 0, 0, 0);
        // Redirect during stall: first target wins
        add(1, 32'h200, 1, 32'h40, 0, 1, 0);
        add(1, 32'h300, 1, 32'h40, 0, 1, 0);
        add(0, 0, 1, 32'h40, 0, 1, 0);
        add(0, 0, 0, 32'h200, 1, 0, 0);
        // Wrong-path redirect ignored, stall extends flush
        add(1, 32'h500, 0, 32'h204, 1, 0, 0);
        add(1, 32'h500, 1, 32'h204, 1, 0, 0);
        add(0, 0, 0, 32'h208, 0, 0, 0);
        add(0, 0, 0, 32'h20C, 0, 0, 0);
        // Misaligned target
        add(1, 32'h106, 0, EXP_MIS, 1, 0, MIS_EN);
        add(0, 0, 0, EXP_MIS + 32'd4, 1, 0, 0);
        add(0, 0, 0, EXP_MIS + 32'd8, 0, 0, 0);
        // HOLD then redirect as stall drops
        add(0, 0, 1, EXP_MIS + 32'd8, 0, 0, 0);
        add(1, 32'h1000, 0, 32'h1000, 1, 0, 0);
        add(0, 0, 0, 32'h1004, 1, 0, 0);
        add(0, 0, 0, 32'h1008, 0, 0, 0);
        // Wraparound
        add(1, 32'hFFFF_FFF8, 0, 32'hFFFF_FFF8, 1, 0, 0);
        add(0, 0, 0, 32'hFFFF_FFFC, 1, 0, 0);
        add(0, 0, 0, 32'h0000_0000, 0, 0, 0);
        add(0, 0, 0, 32'h0000_0004, 0, 0, 0);

        #2;
        check_all("reset_async", RV, 0, 0, 0);
        @(negedge CLK);
        check_all("reset_held", RV, 0, 0, 0);
        RESET = 1'b1;

        foreach (vt[i]) run_vec($sformatf("vec%0d", i), vt[i]);

        // Reset asserted mid-flush takes effect without a clock edge
        redir = 1'b1; tgt = 32'h600; bw = 1'b0;
        @(posedge CLK); #1;
        check_all("pre_reset_flush", 32'h600, 1, 0, 0);
        #2 RESET = 1'b0;
        #1 check_all("reset_midflush", RV, 0, 0, 0);
        @(negedge CLK);
        RESET = 1'b1; redir = 1'b0; tgt = '0;
        begin
            vec_t v;
            v.r = 0; v.t = 0; v.b = 0; v.pc = RV + 32'd4; v.f = 0; v.p = 0; v.tr = 0;
            run_vec("after_reset", v);
        end

        // Randomized run against the model
        RESET = 1'b0;
        #1 RESET = 1'b1;
        m_pc = RV; m_pt = '0; m_left = 0; m_pend = 1'b0; m_trap = 1'b0;
        for (int unsigned k = 0; k < 600; k++) begin
            redir = ($urandom_range(0, 3) == 0);
            bw    = ($urandom_range(0, 2) == 0);
            tgt   = $urandom;
            model_step(redir, tgt, bw);
            @(posedge CLK); #1;
            check_all($sformatf("rnd%0d", k), m_pc, (m_left > 0), m_pend, m_trap);
            @(negedge CLK);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
